avalon_msg_generator: RTL

AVALON_MSG_GENERATOR -- requirements
Module: avalon_msg_generator

---
 rtl/general_pack.sv | 27 ++
 rtl/avalon_st_if.sv | 15 +
 rtl/avalon_msg_generator_beat_former.sv | 28 ++
 rtl/avalon_msg_generator.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/general_pack.sv
// general_pack: shared types and elaboration-time helpers for the message generator.
package general_pack;

    // Generator control states.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } msg_gen_sm_t;

    // Ceiling log2. The result is never less than 1, so a 1-bit field is always available.
    function automatic int unsigned log2up_func(input int unsigned value);
        int unsigned result;
        result = 1;
        for (int unsigned i = 1; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Integer ceiling division. Used to get the beat count from a byte length.
    function automatic int unsigned ceil_div_func(input int unsigned num, input int unsigned den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/avalon_st_if.sv
// avalon_st_if: Avalon-ST style streaming bundle with sop/eop/empty framing.
interface avalon_st_if #(
    parameter int DATA_W  = 128,
    parameter int EMPTY_W = 4
);
    logic [DATA_W-1:0]  data;
    logic [EMPTY_W-1:0] empty;
    logic               sop;
    logic               eop;
    logic               valid;
    logic               rdy;

    modport master (output data, output empty, output sop, output eop, output valid, input rdy);
    modport slave  (input data, input empty, input sop, input eop, input valid, output rdy);
endinterface

// File: rtl/avalon_msg_generator_beat_former.sv
// msg_beat_former: builds one beat of payload. The first byte is in the MSB lane.
// Byte j of beat b is seed + b*W + j, taken mod 256. The trailing 'empty' lanes are zero.
module msg_beat_former
    import general_pack::*;
#(
    parameter int W       = 16,
    parameter int EMPTY_W = log2up_func(W)
) (
    input  logic [7:0]         seed,
    input  logic [7:0]         beat_idx,
    input  logic [EMPTY_W-1:0] empty,
    output logic [W*8-1:0]     data
);

    logic [7:0] base;

    // Fill each byte lane with its running payload value, or zero when the lane is unused.
    always_comb begin
        data = '0;
        base = seed + beat_idx * 8'(W);
        for (int unsigned j = 0; j < W; j++) begin
            if (j < (W - 32'(empty))) begin
                data[(W-1-j)*8 +: 8] = base + 8'(j);
            end
        end
    end

endmodule

// File: rtl/avalon_msg_generator.sv
// avalon_msg_generator: takes one (len, seed) command and turns it into a framed stream
// of incrementing bytes.
// Optional feature: define AVALON_MSG_GEN_ERR_INJ_EN to add the inj_drop_sop input. When
// that input is high at acceptance, sop is suppressed for the whole message.
module avalon_msg_generator
    import general_pack::*;
#(
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int LEN_WIDTH           = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_rdy,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic [7:0]           cmd_seed,
`ifdef AVALON_MSG_GEN_ERR_INJ_EN
    input  logic                 inj_drop_sop,
`endif
    avalon_st_if.master          msg_out,
    output logic                 busy,
    output logic                 done,
    output logic                 len_err
);

    localparam int W       = DATA_WIDTH_IN_BYTES;
    localparam int EMPTY_W = log2up_func(W);

    msg_gen_sm_t          state;
    logic [7:0]           seed_q;
    logic [LEN_WIDTH-1:0] beats_q;
    logic [LEN_WIDTH-1:0] beat_idx_q;
    logic [EMPTY_W-1:0]   last_empty_q;
    logic                 valid_q;
    logic                 sop_q;
    logic                 eop_q;
    logic [EMPTY_W-1:0]   empty_q;
    logic [W*8-1:0]       data_q;

    logic                 accept;
    logic                 xfer;
    logic [LEN_WIDTH-1:0] cmd_beats;
    logic [EMPTY_W-1:0]   cmd_last_empty;
    logic                 cmd_single;
    logic [LEN_WIDTH-1:0] next_idx;
    logic                 next_is_last;
    logic [7:0]           fmt_seed;
    logic [7:0]           fmt_idx;
    logic [EMPTY_W-1:0]   fmt_empty;
    logic [W*8-1:0]       fmt_data;
    logic                 drop_sop;

`ifdef AVALON_MSG_GEN_ERR_INJ_EN
    assign drop_sop = inj_drop_sop;
`else
    assign drop_sop = 1'b0;
`endif

    // Command decode, and selection of the beat that gets registered at the next edge.
    // In IDLE that beat is beat 0 of the offered command. In SEND it is the beat after
    // the one being presented.
    always_comb begin
        accept         = cmd_valid & cmd_rdy;
        xfer           = valid_q & msg_out.rdy;
        cmd_beats      = LEN_WIDTH'(ceil_div_func(32'(cmd_len), W));
        cmd_last_empty = EMPTY_W'(32'(cmd_beats) * W - 32'(cmd_len));
        cmd_single     = (cmd_beats == LEN_WIDTH'(1));
        next_idx       = beat_idx_q + LEN_WIDTH'(1);
        next_is_last   = (next_idx == beats_q - LEN_WIDTH'(1));
        if (state == IDLE) begin
            fmt_seed  = cmd_seed;
            fmt_idx   = '0;
            fmt_empty = cmd_single ? cmd_last_empty : '0;
        end else begin
            fmt_seed  = seed_q;
            fmt_idx   = 8'(next_idx);
            fmt_empty = next_is_last ? last_empty_q : '0;
        end
    end

    msg_beat_former #(
        .W       (W),
        .EMPTY_W (EMPTY_W)
    ) u_former (
        .seed     (fmt_seed),
        .beat_idx (fmt_idx),
        .empty    (fmt_empty),
        .data     (fmt_data)
    );

    // Control FSM with all stream and status outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            cmd_rdy      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            len_err      <= 1'b0;
            seed_q       <= '0;
            beats_q      <= '0;
            beat_idx_q   <= '0;
            last_empty_q <= '0;
            valid_q      <= 1'b0;
            sop_q        <= 1'b0;
            eop_q        <= 1'b0;
            empty_q      <= '0;
            data_q       <= '0;
        end else begin
            done    <= 1'b0;
            len_err <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_rdy <= 1'b1;
                    if (accept) begin
                        if (cmd_len == '0) begin
                            len_err <= 1'b1;
                            done    <= 1'b1;
                        end else begin
                            state        <= SEND;
                            cmd_rdy      <= 1'b0;
                            busy         <= 1'b1;
                            seed_q       <= cmd_seed;
                            beats_q      <= cmd_beats;
                            beat_idx_q   <= '0;
                            last_empty_q <= cmd_last_empty;
                            valid_q      <= 1'b1;
                            sop_q        <= ~drop_sop;
                            eop_q        <= cmd_single;
                            empty_q      <= fmt_empty;
                            data_q       <= fmt_data;
                        end
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (eop_q) begin
                            state   <= IDLE;
                            cmd_rdy <= 1'b1;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            valid_q <= 1'b0;
                            sop_q   <= 1'b0;
                            eop_q   <= 1'b0;
                            empty_q <= '0;
                            data_q  <= '0;
                        end else begin
                            beat_idx_q <= next_idx;
                            sop_q      <= 1'b0;
                            eop_q      <= next_is_last;
                            empty_q    <= fmt_empty;
                            data_q     <= fmt_data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign msg_out.valid = valid_q;
    assign msg_out.sop   = sop_q;
    assign msg_out.eop   = eop_q;
    assign msg_out.empty = empty_q;
    assign msg_out.data  = data_q;

endmodule
